// File: rtl/dense_argmax.sv
// dense_argmax: picks the winning class from one frame of signed dense-layer
// scores. A frame is captured in a single cycle, then scanned one score per
// cycle while a running best/runner-up pair is kept. The winner index, its
// score and its lead over the runner-up are published when the scan ends.
// Class indices are carried in 4 bits, so NC is expected to be at most 15.
module dense_argmax #(
  parameter int NC = 9,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] scores [0:NC],
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           classIdx,
  output logic signed [DW-1:0] maxScore,
  output logic [DW:0]          margin
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic signed [DW-1:0] MINVAL  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [3:0]           LASTIDX = 4'(NC);

  state_t state;
  state_t nextState;

  logic signed [DW-1:0] held [0:NC];
  logic signed [DW-1:0] best;
  logic signed [DW-1:0] second;
  logic [3:0]           bestIdx;
  logic [3:0]           idx;

  logic signed [DW-1:0] cur;
  logic signed [DW-1:0] nextBest;
  logic signed [DW-1:0] nextSecond;
  logic [3:0]           nextBestIdx;
  logic [DW:0]          nextMargin;
  logic                 lastScan;

  assign lastScan = (idx == LASTIDX);

  // The lead is formed on sign-extended operands so it can never wrap.
  assign nextMargin = {nextBest[DW-1], nextBest} - {nextSecond[DW-1], nextSecond};

  // Running top-two update for the score under the scan pointer; strict
  // comparisons keep the lowest index on ties.
  always_comb begin
    cur         = held[idx];
    nextBest    = best;
    nextSecond  = second;
    nextBestIdx = bestIdx;
    if (cur > best) begin
      nextSecond  = best;
      nextBest    = cur;
      nextBestIdx = idx;
    end else if (cur > second) begin
      nextSecond = cur;
    end
  end

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: only IDLE listens to start, DONE lasts one cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start)    nextState = SCAN;
      SCAN:    if (lastScan) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Frame capture, scan datapath and result publication.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= NC; k++) begin
        held[k] <= '0;
      end
      best     <= '0;
      second   <= '0;
      bestIdx  <= '0;
      idx      <= '0;
      classIdx <= '0;
      maxScore <= '0;
      margin   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k <= NC; k++) begin
              held[k] <= scores[k];
            end
            best    <= scores[0];
            second  <= MINVAL;
            bestIdx <= '0;
            idx     <= 4'd1;
          end
        end
        SCAN: begin
          best    <= nextBest;
          second  <= nextSecond;
          bestIdx <= nextBestIdx;
          idx     <= idx + 4'd1;
          if (lastScan) begin
            classIdx <= nextBestIdx;
            maxScore <= nextBest;
            margin   <= nextMargin;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: directed frames for dense_argmax, checked every cycle
// against a frame-level reference model plus hand-computed literals.
module tb_dense_argmax;

  localparam int NC = 9;
  localparam int DW = 8;

  typedef logic signed [DW-1:0] frame_t [0:NC];

  localparam logic signed [DW-1:0] NEG = 8'sh80;

  localparam frame_t F1 = '{8'sd3, -8'sd5, 8'sd12, 8'sd7, 8'sd0, -8'sd1, 8'sd12, 8'sd2, NEG, 8'sd11};
  localparam frame_t F2 = '{-8'sd10, -8'sd20, -8'sd30, -8'sd40, -8'sd50, -8'sd60, -8'sd70, -8'sd80, -8'sd90, 8'sd127};
  localparam frame_t F3 = '{NEG, NEG, NEG, NEG, NEG, NEG, NEG, NEG, NEG, NEG};
  localparam frame_t F4 = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd5, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
  localparam frame_t F5 = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9, 8'sd10};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  frame_t               scores;
  logic                 busy;
  logic                 done;
  logic [3:0]           classIdx;
  logic signed [DW-1:0] maxScore;
  logic [DW:0]          margin;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCount = 0;
  int busyCycles = 0;

  int left = 0;
  int pendIdx = 0;
  int pendMax = 0;
  int pendMargin = 0;
  int pubIdx = 0;
  int pubMax = 0;
  int pubMargin = 0;

  dense_argmax #(.NC(NC), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .scores   (scores),
    .busy     (busy),
    .done     (done),
    .classIdx (classIdx),
    .maxScore (maxScore),
    .margin   (margin)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Edge counter used to measure spacing between done pulses.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Winner is the first index holding the largest score; runner-up is the
  // largest score among all other indices.
  function automatic void refArgmax(input frame_t f, output int idxO, output int maxO,
                                    output int marginO);
    int win = 0;
    int ru = -1000000;
    for (int k = 1; k <= NC; k++) begin
      if (int'(f[k]) > int'(f[win])) win = k;
    end
    for (int k = 0; k <= NC; k++) begin
      if (k != win && int'(f[k]) > ru) ru = int'(f[k]);
    end
    idxO    = win;
    maxO    = int'(f[win]);
    marginO = int'(f[win]) - ru;
  endfunction

  // Frame-level model: an accepted frame keeps the block busy for NC+1
  // cycles and publishes its result in the last of them.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      left      = 0;
      pubIdx    = 0;
      pubMax    = 0;
      pubMargin = 0;
    end else if (left == 0) begin
      if (start === 1'b1) begin
        refArgmax(scores, pendIdx, pendMax, pendMargin);
        left = NC + 1;
      end
    end else begin
      left--;
      if (left == 1) begin
        pubIdx    = pendIdx;
        pubMax    = pendMax;
        pubMargin = pendMargin;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    checkOutput("busy", int'(busy), (left > 0) ? 1 : 0);
    checkOutput("done", int'(done), (left == 1) ? 1 : 0);
    checkOutput("classIdx", int'(classIdx), pubIdx);
    checkOutput("maxScore", int'(maxScore), pubMax);
    checkOutput("margin", int'(margin), pubMargin);
    if (done === 1'b1) doneCount++;
    if (busy === 1'b1) busyCycles++;
  end

  task automatic fillJunk();
    for (int k = 0; k <= NC; k++) scores[k] = 8'sd127;
  endtask

  // Presents a frame with a one-cycle start, then scrambles the score bus.
  task automatic applyStimulus(input frame_t f);
    @(posedge clk);
    #2;
    scores = f;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    fillJunk();
  endtask

  // Waits for done; reports edges after the start edge and the cycle stamp.
  task automatic waitDone(input string name, output int edges, output int stamp);
    edges = -1;
    stamp = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        edges = k - 1;
        stamp = cyc;
        break;
      end
    end
    if (edges < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: done not seen within 40 cycles", name);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int e;
    int s1;
    int s2;
    int base;

    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k <= NC; k++) scores[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetClassIdx", int'(classIdx), 0);
    checkOutput("resetMargin", int'(margin), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    $display("[TB] frame with tied maximum");
    applyStimulus(F1);
    waitDone("t1", e, s1);
    checkOutput("t1Latency", e, 9);
    checkOutput("t1ClassIdx", int'(classIdx), 2);
    checkOutput("t1MaxScore", int'(maxScore), 12);
    checkOutput("t1Margin", int'(margin), 0);

    $display("[TB] frame won by last class");
    repeat (2) @(posedge clk);
    applyStimulus(F2);
    waitDone("t2", e, s1);
    checkOutput("t2ClassIdx", int'(classIdx), 9);
    checkOutput("t2MaxScore", int'(maxScore), 127);
    checkOutput("t2Margin", int'(margin), 137);

    $display("[TB] all scores at most-negative value");
    repeat (2) @(posedge clk);
    busyCycles = 0;
    applyStimulus(F3);
    waitDone("t3", e, s1);
    checkOutput("t3ClassIdx", int'(classIdx), 0);
    checkOutput("t3MaxScore", int'(maxScore), -128);
    checkOutput("t3Margin", int'(margin), 0);
    repeat (3) @(posedge clk);
    checkOutput("t3BusyCycles", busyCycles, 10);

    $display("[TB] start pulses while busy are ignored");
    base = doneCount;
    applyStimulus(F4);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #2;
      start = (c == 2 || c == 8 || c == 9) ? 1'b1 : 1'b0;
      for (int k = 0; k <= NC; k++) scores[k] = 8'($urandom_range(0, 255));
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    checkOutput("t4DoneCount", doneCount - base, 1);
    checkOutput("t4ClassIdx", int'(classIdx), 5);
    checkOutput("t4MaxScore", int'(maxScore), 5);
    checkOutput("t4Margin", int'(margin), 5);

    $display("[TB] reset in the middle of a scan");
    base = doneCount;
    applyStimulus(F1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5Busy", int'(busy), 0);
    checkOutput("t5Done", int'(done), 0);
    checkOutput("t5ClassIdx", int'(classIdx), 0);
    checkOutput("t5MaxScore", int'(maxScore), 0);
    checkOutput("t5Margin", int'(margin), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    checkOutput("t5NoDone", doneCount - base, 0);
    applyStimulus(F5);
    waitDone("t5b", e, s1);
    checkOutput("t5ClassIdxAfter", int'(classIdx), 9);
    checkOutput("t5MaxScoreAfter", int'(maxScore), 10);
    checkOutput("t5MarginAfter", int'(margin), 1);

    $display("[TB] back-to-back frames");
    repeat (2) @(posedge clk);
    applyStimulus(F2);
    waitDone("t6a", e, s1);
    @(posedge clk);
    #2;
    scores = F1;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    fillJunk();
    waitDone("t6b", e, s2);
    checkOutput("t6Spacing", s2 - s1, 11);
    checkOutput("t6ClassIdx", int'(classIdx), 2);
    checkOutput("t6MaxScore", int'(maxScore), 12);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_argmax.md
DENSE_ARGMAX -- requirements
Module: dense_argmax

Interface
REQ-001 Parameter NC, default 9, meaning highest class index; NC+1 scores per frame; NC >= 1.
REQ-002 Parameter DW, default 8, meaning signed score width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  frame-valid strobe; scores valid in the same cycle.
REQ-006 scores  input  signed DW x (NC+1), indexed 0..NC  per-class dense-layer results.
REQ-007 busy  output  1  high whenever the block is not idle; start is ignored while high.
REQ-008 done  output  1  single-cycle pulse; class, maxScore and margin are valid from this cycle.
REQ-009 classIdx  output  4  index of the winning class.
REQ-010 maxScore  output  signed DW  winning score.
REQ-011 margin  output  DW+1, unsigned value  winning score minus runner-up score.

Function
REQ-012 FSM states: IDLE, SCAN, DONE; busy = (state != IDLE).
REQ-013 IDLE with start=1 captures all NC+1 scores into internal registers.
- Same edge: best=score[0], bestIdx=0, second=most-negative DW value (-128 for DW=8), index i=1.
- Same edge: next state SCAN.
REQ-014 IDLE with start=0 holds state; outputs hold their last values.
REQ-015 SCAN processes one captured score per cycle, reg[i], with strictly signed comparisons:
- if reg[i] > best: second=best, best=reg[i], bestIdx=i;
- else if reg[i] > second: second=reg[i];
- i increments by one.
REQ-016 SCAN with i==NC applies REQ-015 to reg[NC] and transitions to DONE; no index beyond NC is read.
REQ-017 Entering DONE registers classIdx=bestIdx, maxScore=best, margin=best-second, with margin computed after sign extension to DW+1 bits (no overflow).
REQ-018 DONE asserts done=1 for exactly one cycle, then returns unconditionally to IDLE.
REQ-019 Latency: with the start-sampling edge as edge 0, done is high in the cycle following edge NC (9 edges for NC=9).
- Minimum start-to-start spacing is NC+2 cycles.
REQ-020 Ties: the lowest index wins (strict >); a tie for the maximum yields margin 0.
REQ-021 Captured scores are immune to changes on scores after the capture edge.
REQ-022 start asserted during SCAN or DONE is ignored entirely; no queuing.
REQ-023 classIdx, maxScore and margin change only on DONE entry and hold until the next DONE entry.
REQ-024 With all scores equal to -128: classIdx=0, maxScore=-128, margin=0.

Reset
REQ-025 While rst=0: state=IDLE, busy=0, done=0, classIdx=0, maxScore=0, margin=0, i=0, and all internal score, best and second registers are 0.
REQ-026 Reset asserted mid-SCAN or during DONE aborts the frame immediately.
- No done pulse is issued for the aborted frame.
- The first start after reset release is accepted normally.

Verification
REQ-027 Scores {3,-5,12,7,0,-1,12,2,-128,11}, start for one cycle -> done exactly 9 edges after start edge; classIdx=2, maxScore=12, margin=0.
REQ-028 Scores {-10,-20,-30,-40,-50,-60,-70,-80,-90,127} -> classIdx=9, maxScore=127, margin=137.
REQ-029 All scores -128 -> classIdx=0, maxScore=-128, margin=0; busy high for exactly 10 cycles.
REQ-030 Frame A {0,0,0,0,0,5,0,0,0,0} followed by start pulses and score changes at cycles 3 and 9 after the start edge -> single done, classIdx=5, margin=5; no second frame.
REQ-031 rst pulled low at cycle 4 of SCAN -> all outputs 0 at once, no done. Then frame {1,2,3,4,5,6,7,8,9,10} -> classIdx=9, maxScore=10, margin=1.
REQ-032 Back-to-back frames, start re-asserted in the IDLE cycle right after done -> both frames complete; second done occurs 11 cycles after the first.
